// File: rtl/mem_arbiter.sv
// Two-port SRAM arbiter: an instruction-fetch port and a data port share one
// multi-cycle SRAM. Each access runs IDLE -> ACCESS (WAIT_CYCLES) -> RESP.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              stall,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_mem_q, last_mem_d;
  logic              gnt_mem_q, gnt_mem_d;
  logic              gnt_we_q, gnt_we_d;
  logic [ADDR_W-1:0] gnt_addr_q, gnt_addr_d;
  logic [31:0]       gnt_wdata_q, gnt_wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic              sram_cs_q, sram_cs_d;
  logic              sram_we_q, sram_we_d;

  logic              mem_req;
  logic              pick_mem;

  assign mem_req  = mem_rd_en | mem_wr_en;
  // On a tie the data stage wins unless it also won the previous grant.
  assign pick_mem = mem_req & (~if_req | ~last_mem_q);

  always_comb begin
    // NOTE: every _d starts from its _q (or a pulse default) so that no path
    // through the case leaves a variable unassigned and infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_mem_d  = last_mem_q;
    gnt_mem_d   = gnt_mem_q;
    gnt_we_d    = gnt_we_q;
    gnt_addr_d  = gnt_addr_q;
    gnt_wdata_d = gnt_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    sram_cs_d   = sram_cs_q;
    sram_we_d   = sram_we_q;

    case (state_q)
      IDLE: begin
        if (if_req | mem_req) begin
          state_d     = ACCESS;
          cnt_d       = CNT_LOAD;
          last_mem_d  = pick_mem;
          gnt_mem_d   = pick_mem;
          gnt_we_d    = pick_mem & mem_wr_en;
          gnt_addr_d  = pick_mem ? mem_addr : if_addr;
          gnt_wdata_d = mem_wdata;
          sram_cs_d   = 1'b1;
          sram_we_d   = pick_mem & mem_wr_en;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d   = RESP;
          sram_cs_d = 1'b0;
          sram_we_d = 1'b0;
          // SRAM data is valid now, on the last access cycle of a read.
          if (!gnt_we_q) begin
            if (gnt_mem_q) mem_rdata_d = sram_rdata;
            else           if_rdata_d  = sram_rdata;
          end
          if (gnt_mem_q) mem_ready_d = 1'b1;
          else           if_ready_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_mem_q  <= 1'b0;
      gnt_mem_q   <= 1'b0;
      gnt_we_q    <= 1'b0;
      gnt_addr_q  <= '0;
      gnt_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      sram_cs_q   <= 1'b0;
      sram_we_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_mem_q  <= last_mem_d;
      gnt_mem_q   <= gnt_mem_d;
      gnt_we_q    <= gnt_we_d;
      gnt_addr_q  <= gnt_addr_d;
      gnt_wdata_q <= gnt_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      sram_cs_q   <= sram_cs_d;
      sram_we_q   <= sram_we_d;
    end
  end

  assign if_rdata   = if_rdata_q;
  assign if_ready   = if_ready_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_ready  = mem_ready_q;
  assign sram_cs    = sram_cs_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = gnt_addr_q;
  assign sram_wdata = gnt_wdata_q;
  assign stall      = (if_req & ~if_ready_q) | (mem_req & ~mem_ready_q);

endmodule
